// File: rtl/dac8734_pkg.sv
// Shared definitions for the DAC8734 serial transmit path.
//   FRAME_BITS / NUM_DAC / CH_PER_DAC : frame and device geometry
//   job_e   : which bank request the engine is serving
//   state_e : engine and shifter states (each module uses its own subset)
//   build_write_frame : 24-bit data-register write frame for one channel
//   dev_onehot / lowest_set : device-select helpers
package dac8734_pkg;

  localparam int FRAME_BITS = 24;
  localparam int NUM_DAC    = 5;
  localparam int CH_PER_DAC = 4;
  localparam int NUM_CH     = NUM_DAC * CH_PER_DAC;

  localparam logic [5:0] DATA_REG_BASE = 6'h08;
  localparam logic       WRITE_BIT     = 1'b0;

  typedef enum logic { JOB_OUTPUT, JOB_SET } job_e;

  typedef enum logic [2:0] {
    ST_IDLE, ST_LOAD, ST_CS_SETUP, ST_SHIFT, ST_CS_HOLD, ST_GAP, ST_DONE_WAIT
  } state_e;

  function automatic logic [FRAME_BITS-1:0] build_write_frame(input logic [1:0]  ch,
                                                              input logic [15:0] data);
    return {WRITE_BIT, 1'b0, DATA_REG_BASE + {4'b0000, ch}, data};
  endfunction

  function automatic logic [NUM_DAC-1:0] dev_onehot(input logic [2:0] dev);
    logic [NUM_DAC-1:0] one;
    one = '0;
    one[0] = 1'b1;
    return one << dev;
  endfunction

  // {found, index} of the lowest set bit
  function automatic logic [3:0] lowest_set(input logic [NUM_DAC-1:0] m);
    logic [3:0] r;
    r = '0;
    for (int i = NUM_DAC - 1; i >= 0; i--)
      if (m[i]) r = {1'b1, 3'(i)};
    return r;
  endfunction

endpackage

// File: rtl/dac8734_frame_shifter.sv
// Shifts one 24-bit frame out to a single DAC8734: nCS setup, 24 SCLK
// periods (SDI updated on rising SCLK, sampled by the DAC on falling),
// nCS hold, then the inter-frame gap.
//   load/frame/dev : frame request (accepted when idle or in the last gap cycle)
//   busy           : frame or gap in progress
//   frame_done     : last gap cycle; a load in this cycle starts back-to-back
//   sclk/ncs/sdi   : registered device pins
module dac8734_frame_shifter
  import dac8734_pkg::*;
#(
  parameter int HALF_PERIOD = 2,
  parameter int CS_GAP      = 4
) (
  input  logic                  DAC_REF_CLK,
  input  logic                  nRESET,
  input  logic                  load,
  input  logic [FRAME_BITS-1:0] frame,
  input  logic [2:0]            dev,
  output logic                  busy,
  output logic                  frame_done,
  output logic [NUM_DAC-1:0]    sclk,
  output logic [NUM_DAC-1:0]    ncs,
  output logic                  sdi
);

  localparam logic [3:0] HP_LAST  = 4'(HALF_PERIOD - 1);
  localparam logic [3:0] GAP_LAST = 4'(CS_GAP - 1);

  state_e                state_q, state_d;
  logic [3:0]            cnt_q;
  logic [4:0]            bit_q;     // bits already launched minus one
  logic                  ph_q;      // 1: SCLK high half
  logic [2:0]            dev_q;
  logic [FRAME_BITS-1:0] sr_q;
  logic                  hp_last, gap_last, last_bit, accept;

  assign hp_last    = (cnt_q == HP_LAST);
  assign gap_last   = (cnt_q == GAP_LAST);
  assign last_bit   = (bit_q == 5'd23);
  // Ending the gap on the same cycle a new load is taken keeps the frame
  // period at exactly 50 half-periods plus CS_GAP.
  assign frame_done = (state_q == ST_GAP) && gap_last;
  assign accept     = load && ((state_q == ST_IDLE) || frame_done);
  assign busy       = (state_q != ST_IDLE);

  always_ff @(posedge DAC_REF_CLK or negedge nRESET)
    if (!nRESET) state_q <= ST_IDLE;
    else         state_q <= state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (accept) state_d = ST_CS_SETUP;
      ST_CS_SETUP: if (hp_last) state_d = ST_SHIFT;
      ST_SHIFT:    if (hp_last && !ph_q && last_bit) state_d = ST_CS_HOLD;
      ST_CS_HOLD:  if (hp_last) state_d = ST_GAP;
      ST_GAP:      if (gap_last) state_d = accept ? ST_CS_SETUP : ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge DAC_REF_CLK or negedge nRESET)
    if (!nRESET) begin
      cnt_q <= '0;
      bit_q <= '0;
      ph_q  <= 1'b0;
      dev_q <= '0;
      sr_q  <= '0;
      sclk  <= '0;
      ncs   <= '1;
      sdi   <= 1'b0;
    end else begin
      // phase counter restarts on every state change and every SCLK half
      if ((state_d != state_q) || ((state_q == ST_SHIFT) && hp_last)) cnt_q <= '0;
      else if (state_q != ST_IDLE)                                    cnt_q <= cnt_q + 4'd1;

      if (accept) begin
        sr_q  <= frame;
        dev_q <= dev;
        sdi   <= frame[FRAME_BITS-1];
        ncs   <= ~dev_onehot(dev);
        sclk  <= '0;
        bit_q <= '0;
        ph_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_CS_SETUP: if (hp_last) begin
            sclk <= dev_onehot(dev_q);
            ph_q <= 1'b1;
            sdi  <= sr_q[FRAME_BITS-1];
            sr_q <= {sr_q[FRAME_BITS-2:0], 1'b0};
          end
          ST_SHIFT: if (hp_last) begin
            if (ph_q) begin
              sclk <= '0;
              ph_q <= 1'b0;
            end else if (!last_bit) begin
              sclk  <= dev_onehot(dev_q);
              ph_q  <= 1'b1;
              sdi   <= sr_q[FRAME_BITS-1];
              sr_q  <= {sr_q[FRAME_BITS-2:0], 1'b0};
              bit_q <= bit_q + 5'd1;
            end
          end
          ST_CS_HOLD: if (hp_last) begin
            ncs <= '1;
            sdi <= 1'b0;
          end
          default: ;
        endcase
      end
    end

endmodule

// File: rtl/dac8734_serial_engine.sv
// DAC8734 serial engine: synchronizes the bank's TX_START / SET_START levels,
// sequences either the 20 channel-write frames or the raw SET frames through
// the frame shifter, and answers with READY / OUTPUT_DONE / SET_DONE levels.
//   DAC_REF_CLK, nRESET           : engine clock, async active-low reset
//   TX_START, SET_START           : request levels from the 100 MHz bank
//   DAC_OUTPUT_DATA, SET_BUFFER0/1: quasi-static data, stable while READY=1
//   DAC_SCLK, DAC_nCS, DAC_SDI    : device pins
//   DAC_READY, DAC_OUTPUT_DONE, DAC_SET_DONE : 4-phase handshake back to the bank
module dac8734_serial_engine
  import dac8734_pkg::*;
#(
  parameter int HALF_PERIOD = 2,
  parameter int CS_GAP      = 4
) (
  input  logic                  DAC_REF_CLK,
  input  logic                  nRESET,
  input  logic                  TX_START,
  input  logic [NUM_DAC-1:0]    SET_START,
  input  logic [16*NUM_CH-1:0]  DAC_OUTPUT_DATA,
  input  logic [15:0]           SET_BUFFER0,
  input  logic [15:0]           SET_BUFFER1,
  output logic [NUM_DAC-1:0]    DAC_SCLK,
  output logic [NUM_DAC-1:0]    DAC_nCS,
  output logic                  DAC_SDI,
  output logic                  DAC_READY,
  output logic                  DAC_OUTPUT_DONE,
  output logic                  DAC_SET_DONE
);

  logic               tx_s1, tx_s2;
  logic [NUM_DAC-1:0] set_s1, set_s2;

  always_ff @(posedge DAC_REF_CLK or negedge nRESET)
    if (!nRESET) begin
      tx_s1  <= 1'b0;
      tx_s2  <= 1'b0;
      set_s1 <= '0;
      set_s2 <= '0;
    end else begin
      tx_s1  <= TX_START;
      tx_s2  <= tx_s1;
      set_s1 <= SET_START;
      set_s2 <= set_s1;
    end

  // Engine uses ST_SHIFT to mean "frames in flight in the shifter".
  state_e             state_q, state_d;
  job_e               job_q;
  logic [4:0]         idx_q;     // channel index (OUTPUT) or device (SET)
  logic [NUM_DAC-1:0] mask_q;

  logic                  shf_busy, frame_done, load;
  logic [FRAME_BITS-1:0] frame;
  logic [2:0]            dev;
  logic [3:0]            first_set, above_set;
  logic [NUM_DAC-1:0]    below_mask;
  logic                  more;
  logic [4:0]            nxt_idx, sel_idx;
  logic                  unused_buf_hi;

  assign unused_buf_hi = ^SET_BUFFER1[15:8];   // never transmitted

  assign first_set  = lowest_set(set_s2);
  // devices at or below the current one are already served; 2<<4 wraps to 0
  assign below_mask = (5'd2 << idx_q[2:0]) - 5'd1;
  assign above_set  = lowest_set(mask_q & ~below_mask);

  always_comb begin
    more    = 1'b0;
    nxt_idx = idx_q;
    if (job_q == JOB_OUTPUT) begin
      more    = (idx_q != 5'(NUM_CH - 1));
      nxt_idx = idx_q + 5'd1;
    end else begin
      more    = above_set[3];
      nxt_idx = {2'b00, above_set[2:0]};
    end
  end

  always_ff @(posedge DAC_REF_CLK or negedge nRESET)
    if (!nRESET) state_q <= ST_IDLE;
    else         state_q <= state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (!shf_busy && (tx_s2 || (set_s2 != '0))) state_d = ST_LOAD;
      ST_LOAD:      state_d = ST_SHIFT;
      ST_SHIFT:     if (frame_done && !more) state_d = ST_DONE_WAIT;
      ST_DONE_WAIT: if ((job_q == JOB_OUTPUT) ? !tx_s2 : (set_s2 == '0)) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // job bookkeeping; OUTPUT wins when both requests are present
  always_ff @(posedge DAC_REF_CLK or negedge nRESET)
    if (!nRESET) begin
      job_q  <= JOB_OUTPUT;
      idx_q  <= '0;
      mask_q <= '0;
    end else if ((state_q == ST_IDLE) && (state_d == ST_LOAD)) begin
      job_q  <= tx_s2 ? JOB_OUTPUT : JOB_SET;
      mask_q <= set_s2;
      idx_q  <= tx_s2 ? 5'd0 : {2'b00, first_set[2:0]};
    end else if ((state_q == ST_SHIFT) && frame_done && more) begin
      idx_q  <= nxt_idx;
    end

  always_comb begin
    load    = 1'b0;
    sel_idx = idx_q;
    case (state_q)
      ST_LOAD:  load = 1'b1;
      ST_SHIFT: if (frame_done && more) begin
        load    = 1'b1;
        sel_idx = nxt_idx;
      end
      default: ;
    endcase

    if (job_q == JOB_OUTPUT) begin
      dev   = sel_idx[4:2];
      frame = build_write_frame(sel_idx[1:0], DAC_OUTPUT_DATA[{sel_idx, 4'b0000} +: 16]);
    end else begin
      dev   = sel_idx[2:0];
      frame = {SET_BUFFER1[7:0], SET_BUFFER0};
    end

    DAC_READY       = (state_q == ST_IDLE);
    DAC_OUTPUT_DONE = (state_q == ST_DONE_WAIT) && (job_q == JOB_OUTPUT);
    DAC_SET_DONE    = (state_q == ST_DONE_WAIT) && (job_q == JOB_SET);
  end

  dac8734_frame_shifter #(
    .HALF_PERIOD (HALF_PERIOD),
    .CS_GAP      (CS_GAP)
  ) u_shf (
    .DAC_REF_CLK (DAC_REF_CLK),
    .nRESET      (nRESET),
    .load        (load),
    .frame       (frame),
    .dev         (dev),
    .busy        (shf_busy),
    .frame_done  (frame_done),
    .sclk        (DAC_SCLK),
    .ncs         (DAC_nCS),
    .sdi         (DAC_SDI)
  );

endmodule

// File: tb/tb_dac8734_serial_engine.sv
// Directed bench: a default-timing DUT (HALF_PERIOD=2, CS_GAP=4) and a
// fast DUT (1/1). A pin-level receiver decodes every frame per DUT and
// checks bus invariants each cycle.
module tb_dac8734_serial_engine;

  typedef struct {
    int          dev;
    logic [23:0] data;
    int          nbits;
    int          low;
    int          period;
  } frame_t;

  logic gclk = 1'b0;
  always #5 gclk = ~gclk;

  logic         grst_n, grst_f_n;
  logic         tx, tx_f;
  logic [4:0]   set_m, set_f;
  logic [319:0] out_data, data_f;
  logic [15:0]  buf0, buf1, buf0_f, buf1_f;
  logic [4:0]   sclk0, ncs0, sclk1, ncs1;
  logic         sdi0, sdi1, ready0, ready1, odone0, odone1, sdone0, sdone1;

  dac8734_serial_engine #(.HALF_PERIOD(2), .CS_GAP(4)) u_dut (
    .DAC_REF_CLK(gclk), .nRESET(grst_n), .TX_START(tx), .SET_START(set_m),
    .DAC_OUTPUT_DATA(out_data), .SET_BUFFER0(buf0), .SET_BUFFER1(buf1),
    .DAC_SCLK(sclk0), .DAC_nCS(ncs0), .DAC_SDI(sdi0), .DAC_READY(ready0),
    .DAC_OUTPUT_DONE(odone0), .DAC_SET_DONE(sdone0));

  dac8734_serial_engine #(.HALF_PERIOD(1), .CS_GAP(1)) u_fast (
    .DAC_REF_CLK(gclk), .nRESET(grst_f_n), .TX_START(tx_f), .SET_START(set_f),
    .DAC_OUTPUT_DATA(data_f), .SET_BUFFER0(buf0_f), .SET_BUFFER1(buf1_f),
    .DAC_SCLK(sclk1), .DAC_nCS(ncs1), .DAC_SDI(sdi1), .DAC_READY(ready1),
    .DAC_OUTPUT_DONE(odone1), .DAC_SET_DONE(sdone1));

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- pin-level receiver ----------------
  frame_t      fq0[$], fq1[$];
  int          cyc = 0;
  int          fall_cnt[2], rise_cnt[2], nbits[2], low_start[2], last_fall[2], fdev[2];
  logic [23:0] shreg[2];
  logic [4:0]  p_sclk[2], p_ncs[2];
  logic        p_sdi[2];

  initial
    for (int m = 0; m < 2; m++) begin
      fall_cnt[m] = 0; rise_cnt[m] = 0; nbits[m] = 0; low_start[m] = 0;
      last_fall[m] = -1; fdev[m] = 0; shreg[m] = '0;
      p_sclk[m] = '0; p_ncs[m] = '1; p_sdi[m] = 1'b0;
    end

  always @(negedge gclk) begin
    cyc++;
    for (int m = 0; m < 2; m++) begin
      logic [4:0] s, c;
      logic       d, r;
      frame_t     f;
      s = (m == 0) ? sclk0 : sclk1;
      c = (m == 0) ? ncs0  : ncs1;
      d = (m == 0) ? sdi0  : sdi1;
      r = (m == 0) ? grst_n : grst_f_n;
      if (r) begin
        chk($sformatf("one_cs%0d", m), 64'($countones(~c) <= 1), 1);
        chk($sformatf("sclk_sel%0d", m), 64'((s & c) == 5'd0), 1);
        if (&c) chk($sformatf("sdi_idle%0d", m), d, 0);
        if ((&p_ncs[m]) && !(&c)) begin
          fall_cnt[m]++;
          for (int i = 0; i < 5; i++) if (!c[i]) fdev[m] = i;
          low_start[m] = cyc;
          shreg[m] = '0;
          nbits[m] = 0;
        end
        if ((p_sclk[m] & ~s) != 5'd0) begin
          chk($sformatf("sdi_stable%0d", m), d, p_sdi[m]);
          shreg[m] = {shreg[m][22:0], d};
          nbits[m]++;
        end
        if ((~p_sclk[m] & s) != 5'd0) rise_cnt[m]++;
        if (!(&p_ncs[m]) && (&c)) begin
          f.dev = fdev[m];
          f.data = shreg[m];
          f.nbits = nbits[m];
          f.low = cyc - low_start[m];
          f.period = (last_fall[m] < 0) ? -1 : low_start[m] - last_fall[m];
          last_fall[m] = low_start[m];
          if (m == 0) fq0.push_back(f);
          else        fq1.push_back(f);
        end
      end
      p_sclk[m] = s;
      p_ncs[m]  = c;
      p_sdi[m]  = d;
    end
  end

  // ---------------- helpers ----------------
  function automatic logic sig(input int sel);
    case (sel)
      0:       return odone0;
      1:       return sdone0;
      2:       return ready0;
      3:       return sdone1;
      default: return ready1;
    endcase
  endfunction

  task automatic wait_sig(input int sel, input logic lvl, input int bound, input string tag);
    int n = 0;
    while (sig(sel) !== lvl && n < bound) begin
      @(negedge gclk);
      n++;
    end
    chk(tag, sig(sel), lvl);
  endtask

  // period < 0: first frame of a job, no period expectation
  task automatic chk_frame(input int m, input string tag, input int dev,
                           input logic [23:0] data, input int period);
    frame_t f;
    int sz;
    sz = (m == 0) ? fq0.size() : fq1.size();
    chk({tag, "_present"}, 64'(sz > 0), 1);
    if (sz > 0) begin
      if (m == 0) f = fq0.pop_front();
      else        f = fq1.pop_front();
      chk({tag, "_dev"},  f.dev,   dev);
      chk({tag, "_data"}, f.data,  data);
      chk({tag, "_bits"}, f.nbits, 24);
      chk({tag, "_low"},  f.low,   (m == 0) ? 100 : 50);
      if (period >= 0) chk({tag, "_period"}, f.period, period);
    end
  endtask

  function automatic logic [15:0] word(input int k);
    return (k == 9) ? 16'hA5C3 : 16'(16'h0B3D * k + 16'h0123);
  endfunction

  task automatic chk_output_frames(input string pfx);
    for (int k = 0; k < 20; k++) begin
      if (k == 9 && fq0.size() > 0) chk({pfx, "_dev2ch1_frame"}, fq0[0].data, 24'h09A5C3);
      chk_frame(0, $sformatf("%s_f%0d", pfx, k), k / 4,
                {8'(8'h08 + (k % 4)), word(k)}, (k == 0) ? -1 : 104);
    end
    chk({pfx, "_no_extra_frames"}, fq0.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (checks=%0d)", n_chk);
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    int f0, r0;
    grst_n = 1'b0; grst_f_n = 1'b0;
    tx = 1'b0; tx_f = 1'b0; set_m = '0; set_f = '0;
    out_data = '0; data_f = '0; buf0 = '0; buf1 = '0; buf0_f = '0; buf1_f = '0;
    for (int k = 0; k < 20; k++) out_data[16*k +: 16] = word(k);

    repeat (3) @(negedge gclk);
    chk("rst_sclk", sclk0, 5'b00000);
    chk("rst_ncs", ncs0, 5'b11111);
    chk("rst_sdi", sdi0, 0);
    chk("rst_ready", ready0, 1);
    chk("rst_odone", odone0, 0);
    chk("rst_sdone", sdone0, 0);
    grst_n = 1'b1; grst_f_n = 1'b1;
    repeat (5) @(negedge gclk);
    chk("idle_ready", ready0, 1);
    chk("idle_ncs", ncs0, 5'b11111);

    // fast timing: HALF_PERIOD=1, CS_GAP=1, raw frames to dev0 and dev2
    buf1_f = 16'hAB5A; buf0_f = 16'h00FF; set_f = 5'b00101;
    wait_sig(3, 1'b1, 400, "fast_set_done");
    chk("fast_odone", odone1, 0);
    chk_frame(1, "fast_f0", 0, 24'h5A00FF, -1);
    chk_frame(1, "fast_f1", 2, 24'h5A00FF, 51);
    chk("fast_no_extra", fq1.size(), 0);
    set_f = '0;
    wait_sig(3, 1'b0, 20, "fast_set_done_drop");
    chk("fast_ready_back", ready1, 1);

    // OUTPUT job: 20 channel writes
    tx = 1'b1;
    wait_sig(2, 1'b0, 10, "out_ready_drop");
    wait_sig(0, 1'b1, 3000, "out_done");
    chk("out_sdone_low", sdone0, 0);
    chk_output_frames("out");
    tx = 1'b0;
    wait_sig(0, 1'b0, 20, "out_done_drop");
    chk("out_ready_back", ready0, 1);

    // SET job: mask 10010, upper byte of BUF1 must not appear
    buf1 = 16'hFF3C; buf0 = 16'h1234; set_m = 5'b10010;
    wait_sig(1, 1'b1, 500, "set_done");
    chk("set_odone_low", odone0, 0);
    chk_frame(0, "set_f0", 1, 24'h3C1234, -1);
    chk_frame(0, "set_f1", 4, 24'h3C1234, 104);
    chk("set_no_extra", fq0.size(), 0);
    set_m = '0;
    wait_sig(1, 1'b0, 20, "set_done_drop");
    chk("set_ready_back", ready0, 1);

    // simultaneous requests: OUTPUT first, then SET
    tx = 1'b1; set_m = 5'b00001;
    wait_sig(0, 1'b1, 3000, "sim_out_done");
    chk("sim_sdone_low", sdone0, 0);
    chk_output_frames("sim");
    tx = 1'b0;
    wait_sig(1, 1'b1, 500, "sim_set_done");
    chk("sim_odone_low", odone0, 0);
    chk_frame(0, "sim_set_f0", 0, 24'h3C1234, -1);
    chk("sim_set_no_extra", fq0.size(), 0);
    set_m = '0;
    wait_sig(2, 1'b1, 20, "sim_ready_back");

    // reset in the middle of the third frame
    f0 = fall_cnt[0];
    tx = 1'b1;
    begin
      int n = 0;
      while (fall_cnt[0] < f0 + 3 && n < 600) begin
        @(negedge gclk);
        n++;
      end
    end
    chk("rst_mid_reached_frame3", fall_cnt[0], f0 + 3);
    repeat (30) @(negedge gclk);
    #2;
    grst_n = 1'b0;
    tx = 1'b0;
    r0 = rise_cnt[0];
    @(negedge gclk);
    chk("rst_mid_ncs", ncs0, 5'b11111);
    chk("rst_mid_sclk", sclk0, 5'b00000);
    chk("rst_mid_sdi", sdi0, 0);
    chk("rst_mid_ready", ready0, 1);
    repeat (2) @(negedge gclk);
    grst_n = 1'b1;
    repeat (60) @(negedge gclk);
    chk("rst_mid_no_sclk", rise_cnt[0], r0);
    chk("rst_mid_ready_after", ready0, 1);
    chk("rst_mid_odone_after", odone0, 0);
    fq0.delete();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dac8734_serial_engine.md
Name: dac8734_serial_engine

Overview:
- Serial transmit engine directly downstream of the DAC register bank, running in the DAC_REF_CLK domain.
- Converts the bank's control bits and 20 channel words into 24-bit SPI write frames for five DAC8734 quad DACs.
- The five DACs share one SDI line and each has its own SCLK and nCS.
- Reports READY / OUTPUT_DONE / SET_DONE back to the bank through a level (4-phase) handshake that survives the 100 MHz to DAC_REF_CLK crossing.

Parameters:
HALF_PERIOD, 2, DAC_REF_CLK cycles per SCLK half-period (legal range 1..15)
CS_GAP, 4, DAC_REF_CLK cycles nCS stays high between frames (legal range 1..15)
NUM_DAC, 5, number of DAC8734 devices (fixed at 5; listed for package use)

Ports:
DAC_REF_CLK  in  1  engine clock
nRESET  in  1  asynchronous, active-low reset
TX_START  in  1  level from REG_DAC_CONTROL[0], 100 MHz domain; request write of all 20 channels
SET_START  in  5  level mask from REG_DAC_SETCONTROL[4:0]; request raw frame to each selected device
DAC_OUTPUT_DATA  in  320  channel words; word idx = dev*4+ch at [16*idx +: 16]
SET_BUFFER0  in  16  raw frame bits [15:0]
SET_BUFFER1  in  16  raw frame bits [23:16] taken from [7:0]; [15:8] ignored
DAC_SCLK  out  5  per-device serial clock
DAC_nCS  out  5  per-device chip select, active low
DAC_SDI  out  1  shared serial data, MSB first
DAC_READY  out  1  high when idle and no handshake is pending
DAC_OUTPUT_DONE  out  1  level done for TX_START
DAC_SET_DONE  out  1  level done for SET_START

Behaviour:
- Reset (async assert, sync release): DAC_SCLK=5'b00000, DAC_nCS=5'b11111, DAC_SDI=0, DAC_READY=1, both DONE=0, FSM=IDLE. Reset mid-frame aborts the frame immediately; no partial-frame recovery.
- Inputs: TX_START and SET_START each pass through a 2-flop synchronizer. Data buses are quasi-static (software writes them only while READY=1). They are sampled into the shift register at frame load.
- FSM states: IDLE, LOAD, CS_SETUP, SHIFT, CS_HOLD, GAP, DONE_WAIT.
- IDLE:
  - Synced TX_START=1 → job=OUTPUT, frame list = dev0 ch0..3, dev1 ch0..3, …, dev4 ch3 (20 frames); READY drops on the next edge.
  - Otherwise, synced SET_START!=0 → job=SET, frame list = each set bit, ascending device index.
  - Both requests together: OUTPUT runs first; SET is served on the next return to IDLE.
- Write frame format: {1'b0 (write), 1'b0, addr[5:0]=6'h08+ch, data[15:0]}.
- Raw SET frame: {SET_BUFFER1[7:0], SET_BUFFER0}.
- LOAD: select device, load the 24-bit frame, DAC_nCS[dev]=0, DAC_SDI=bit23.
- CS_SETUP: HALF_PERIOD cycles.
- SHIFT, per bit (24 bits):
  - DAC_SCLK[dev]=1 for HALF_PERIOD cycles; SDI changes only on the cycle SCLK rises.
  - Then DAC_SCLK[dev]=0 for HALF_PERIOD cycles; the DAC samples on the falling edge.
  - Non-selected SCLK bits stay 0.
- CS_HOLD: SCLK low for HALF_PERIOD cycles, then nCS[dev]=1.
- GAP: CS_GAP cycles with all nCS high and SDI=0. Then LOAD the next frame, or go to DONE_WAIT after the last frame.
- Frame period from nCS fall to next nCS fall = 50*HALF_PERIOD + CS_GAP (104 cycles at defaults).
- DONE_WAIT:
  - Assert the matching DONE level and hold it until the synced request goes fully low (TX_START=0, or SET_START=0).
  - Then drop DONE and return to IDLE; READY=1 on the same edge.
  - If the request drops early (bank reset), DONE still pulses at least 1 cycle.
- SET_START mask == 0 never starts a job. SET_BUFFER1[15:8] is never transmitted.
- At most one nCS is low at any time. SDI is driven only between nCS fall and nCS rise; otherwise 0.

Decomposition:
- Package dac8734_pkg:
  - FRAME_BITS=24, NUM_DAC=5, CH_PER_DAC=4
  - DATA_REG_BASE=6'h08, WRITE_BIT=1'b0
  - job enum {JOB_OUTPUT, JOB_SET}
  - FSM state enum
  - function build_write_frame(ch, data)
- Sub-module dac8734_frame_shifter:
  - Interface: load, frame[23:0], dev[2:0] in; busy, frame_done out; drives SCLK/nCS/SDI.
  - Implements CS_SETUP..GAP.
  - The engine keeps sequencing, synchronizers and the handshake.

Test Plan:
- Reset during SHIFT of frame 3 → next cycle nCS=11111, SCLK=00000, SDI=0, READY=1; no further SCLK edges.
- Channel sequence: DAC2 ch1 = 0xA5C3, TX_START=1 → frame 10 on nCS[2] carries 24'h09A5C3 MSB first, sampled on SCLK falls. Exactly 20 frames, in order dev0 ch0 → dev4 ch3. Then OUTPUT_DONE=1; after TX_START drops, DONE=0 and READY=1. Total busy ≈ 20*104 cycles + sync.
- Raw SET frame: SET_START=5'b10010, BUF1=0xFF3C, BUF0=0x1234 → two frames 24'h3C1234, first on dev1 then dev4; SET_DONE=1; OUTPUT_DONE stays 0.
- Simultaneous requests: TX_START=1 and SET_START=5'b00001 asserted the same cycle → 20 output frames, OUTPUT_DONE handshake, then 1 SET frame on dev0, then SET_DONE.
- Timing: HALF_PERIOD=1, CS_GAP=1 → SCLK high 1 / low 1 cycle; nCS low for exactly 50 cycles; gap 1 cycle. Checker: SDI stable across every SCLK falling edge, and never more than one nCS low.
